// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: address width, reset vector and the
// controller's default interrupt vectors.
package cpu_pkg;

    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

    localparam logic [ADDR_W-1:0] INTA_VEC  = 16'hFDA9;
    localparam logic [ADDR_W-1:0] INTB_VEC  = 16'hFB53;
    localparam logic [ADDR_W-1:0] SOFT_VEC0 = 16'h0100;

    // The single action the program counter takes on a given edge.
    typedef enum logic [2:0] {
        ACT_INC  = 3'd0,
        ACT_JUMP = 3'd1,
        ACT_INT  = 3'd2,
        ACT_RET  = 3'd3,
        ACT_HOLD = 3'd4,
        ACT_LOCK = 3'd5
    } pc_action_e;

endpackage

// File: rtl/return_stack.sv
// Register-array LIFO with a level counter; push and pop together
// overwrite the top entry and leave the level unchanged.
module return_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] level_q;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;

    always_comb begin
        top_idx = IW'(level_q - LW'(1));
        wr_idx  = IW'(level_q);
    end

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = empty_o ? '0 : mem_q[top_idx];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && pop_i && !empty_o) begin
                mem_q[top_idx] <= din_i;
            end else if (push_i && !full_o) begin
                mem_q[wr_idx] <= din_i;
                level_q       <= level_q + LW'(1);
            end else if (pop_i && !empty_o) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/program_counter.sv
// 16-bit program counter: increment, jump, interrupt vectoring with a
// hardware return stack, and an interrupt latch that survives lock.
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VEC,
    parameter logic [ADDR_W-1:0] INC_STEP     = 16'd1,
    parameter int                STACK_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [ADDR_W-1:0]                i_data_bus,
    input  logic [ADDR_W-1:0]                i_interrupt_address,
    input  logic                             i_pc_set_enable,
    input  logic                             i_pc_address_enable,
    input  logic                             i_pc_interrupt_enable,
    input  logic                             i_pc_lock,
    input  logic                             i_pc_return,
    output logic [ADDR_W-1:0]                o_pc,
    output logic [ADDR_W-1:0]                o_address,
    output logic                             o_int_ack,
    output logic                             o_int_pending,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_stack_level,
    output logic                             o_stack_overflow,
    output logic                             o_stack_underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pending_q;
    logic [ADDR_W-1:0] pend_vec_q;
    logic              int_ack_q;
    logic              ovf_q, unf_q;

    logic              strobe_irq, irq;
    logic [ADDR_W-1:0] vec;
    pc_action_e        act;
    logic              push, pop, ovf_set, unf_set;
    logic [ADDR_W-1:0] stk_din, stk_dout;
    logic              stk_full, stk_empty;

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (stk_din),
        .dout_o  (stk_dout),
        .level_o (o_stack_level),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        strobe_irq = i_pc_set_enable & i_pc_interrupt_enable;
        irq        = strobe_irq | pending_q;
        vec        = pending_q ? pend_vec_q : i_interrupt_address;
        act        = ACT_INC;
        pc_d       = pc_q + INC_STEP;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (i_pc_lock) begin
            act  = ACT_LOCK;
            pc_d = pc_q;
        end else if (irq && !stk_full) begin
            // A return in the same cycle tail-chains: the popped context stays on top.
            act  = ACT_INT;
            pc_d = vec;
            push = 1'b1;
            pop  = i_pc_return & ~stk_empty;
        end else begin
            // A refused interrupt still lets the PC advance by the normal rules.
            ovf_set = irq;
            if (i_pc_return && !stk_empty) begin
                act  = ACT_RET;
                pc_d = stk_dout;
                pop  = 1'b1;
            end else if (i_pc_return) begin
                act     = ACT_HOLD;
                pc_d    = pc_q;
                unf_set = 1'b1;
            end else if (i_pc_set_enable && !i_pc_interrupt_enable) begin
                act  = ACT_JUMP;
                pc_d = i_data_bus;
            end
        end
        stk_din = pop ? stk_dout : pc_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q       <= RESET_VECTOR;
            pending_q  <= 1'b0;
            pend_vec_q <= '0;
            int_ack_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            int_ack_q <= (act == ACT_INT);
            ovf_q     <= ovf_q | ovf_set;
            unf_q     <= unf_q | unf_set;
            if (i_pc_lock) begin
                if (strobe_irq) begin
                    pending_q  <= 1'b1;
                    pend_vec_q <= i_interrupt_address;
                end
            end else begin
                pending_q <= 1'b0;
            end
        end
    end

    assign o_pc              = pc_q;
    assign o_address         = i_pc_address_enable ? pc_q : '0;
    assign o_int_ack         = int_ack_q;
    assign o_int_pending     = pending_q;
    assign o_stack_overflow  = ovf_q;
    assign o_stack_underflow = unf_q;

endmodule

// File: tb/tb_program_counter.sv
// Scenario bench for program_counter: expected PC values are queued when
// stimulus is driven and popped after the edge that produces them.
module tb_program_counter;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] data_bus = '0, int_addr = '0;
    logic        set_en = 1'b0, aen = 1'b0, int_en = 1'b0, lock = 1'b0, ret = 1'b0;
    logic [15:0] pc, address;
    logic        int_ack, int_pending, ovf, unf;
    logic [2:0]  stack_level;

    logic [15:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    program_counter dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_data_bus            (data_bus),
        .i_interrupt_address   (int_addr),
        .i_pc_set_enable       (set_en),
        .i_pc_address_enable   (aen),
        .i_pc_interrupt_enable (int_en),
        .i_pc_lock             (lock),
        .i_pc_return           (ret),
        .o_pc                  (pc),
        .o_address             (address),
        .o_int_ack             (int_ack),
        .o_int_pending         (int_pending),
        .o_stack_level         (stack_level),
        .o_stack_overflow      (ovf),
        .o_stack_underflow     (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Drive one cycle of controls, then settle 1 time unit past the edge.
    task automatic drive(input logic s, input logic ie, input logic lk, input logic rt,
                         input logic [15:0] bus, input logic [15:0] vec);
        set_en   = s;
        int_en   = ie;
        lock     = lk;
        ret      = rt;
        data_bus = bus;
        int_addr = vec;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        set_en = 0; int_en = 0; lock = 0; ret = 0; aen = 0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        @(negedge clk);
        tests_run++;
        if (pc !== 16'h0000 || stack_level !== 3'd0 || int_ack !== 1'b0 ||
            int_pending !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h lvl=%0d ack=%b pend=%b ovf=%b unf=%b expected 0000/0/0/0/0/0",
                     pc, stack_level, int_ack, int_pending, ovf, unf);
        end
        n_rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            aen = (i == 3);
            exp_q.push_back(16'(i));
            drive(0, 0, 0, 0, 16'h0, 16'h0);
            exp = exp_q.pop_front();
            tests_run++;
            if (pc !== exp) begin
                tests_failed++;
                $display("FAIL idle_inc: o_pc=%h expected %h", pc, exp);
            end
            tests_run++;
            if (address !== (aen ? exp : 16'h0000)) begin
                tests_failed++;
                $display("FAIL address_gate: o_address=%h expected %h", address, aen ? exp : 16'h0000);
            end
        end
        aen = 1'b0;
    endtask

    task automatic test_jump();
        logic [15:0] exp;
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0005);
        exp_q.push_back(16'h1234);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp) begin tests_failed++; $display("FAIL jump_pre: o_pc=%h expected %h", pc, exp); end
        drive(1, 0, 0, 0, 16'h1234, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL jump: o_pc=%h lvl=%0d expected %h lvl 0", pc, stack_level, exp);
        end
    endtask

    task automatic test_interrupt();
        logic [15:0] exp;
        drive(1, 0, 0, 0, 16'h0010, 16'h0);
        exp_q.push_back(INTA_VEC);
        drive(1, 1, 0, 0, 16'h0, INTA_VEC);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd1 || int_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL int_take: o_pc=%h lvl=%0d ack=%b expected %h lvl 1 ack 1", pc, stack_level, int_ack, exp);
        end
        exp_q.push_back(16'h0010);
        drive(0, 0, 0, 1, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd0 || int_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_return: o_pc=%h lvl=%0d ack=%b expected %h lvl 0 ack 0", pc, stack_level, int_ack, exp);
        end
    endtask

    task automatic test_lock_irq();
        logic [15:0] exp;
        drive(1, 0, 0, 0, 16'h0020, 16'h0);
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h0020);
        drive(1, 1, 1, 0, 16'h0, INTB_VEC);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || int_pending !== 1'b1 || int_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_latch: o_pc=%h pend=%b ack=%b expected %h pend 1 ack 0", pc, int_pending, int_ack, exp);
        end
        drive(0, 0, 1, 1, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || int_pending !== 1'b1 || stack_level !== 3'd0 || unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_hold: o_pc=%h pend=%b lvl=%0d unf=%b expected %h pend 1 lvl 0 unf 0",
                     pc, int_pending, stack_level, unf, exp);
        end
        exp_q.push_back(INTB_VEC);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || int_pending !== 1'b0 || stack_level !== 3'd1 || int_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_release: o_pc=%h pend=%b lvl=%0d ack=%b expected %h pend 0 lvl 1 ack 1",
                     pc, int_pending, stack_level, int_ack, exp);
        end
        exp_q.push_back(16'h0020);
        drive(0, 0, 0, 1, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL lock_return: o_pc=%h lvl=%0d expected %h lvl 0", pc, stack_level, exp);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'h1000 + 16'(i));
            drive(1, 1, 0, 0, 16'h0, 16'h1000 + 16'(i));
            exp = exp_q.pop_front();
            tests_run++;
            if (pc !== exp || stack_level !== 3'(i + 1) || ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL nest_push: o_pc=%h lvl=%0d ovf=%b expected %h lvl %0d ovf 0", pc, stack_level, ovf, exp, i + 1);
            end
        end
        exp_q.push_back(16'h1004);
        drive(1, 1, 0, 0, 16'h0, INTA_VEC);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd4 || ovf !== 1'b1 || int_ack !== 1'b0 || int_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow: o_pc=%h lvl=%0d ovf=%b ack=%b pend=%b expected %h lvl 4 ovf 1 ack 0 pend 0",
                     pc, stack_level, ovf, int_ack, int_pending, exp);
        end
        exp_q.push_back(16'h1002);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h0000);
        for (int i = 3; i >= 0; i--) begin
            drive(0, 0, 0, 1, 16'h0, 16'h0);
            exp = exp_q.pop_front();
            tests_run++;
            if (pc !== exp || stack_level !== 3'(i)) begin
                tests_failed++;
                $display("FAIL nest_pop: o_pc=%h lvl=%0d expected %h lvl %0d", pc, stack_level, exp, i);
            end
        end
        exp_q.push_back(16'h0000);
        drive(0, 0, 0, 1, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || unf !== 1'b1 || ovf !== 1'b1 || stack_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL underflow: o_pc=%h unf=%b ovf=%b lvl=%0d expected %h unf 1 ovf 1 lvl 0",
                     pc, unf, ovf, stack_level, exp);
        end
    endtask

    task automatic test_tail_chain();
        logic [15:0] exp;
        drive(1, 0, 0, 0, 16'h0040, 16'h0);
        drive(1, 1, 0, 0, 16'h0, 16'h2000);
        exp_q.push_back(SOFT_VEC0);
        drive(1, 1, 0, 1, 16'h0, SOFT_VEC0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd1 || int_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL tail_chain: o_pc=%h lvl=%0d ack=%b expected %h lvl 1 ack 1", pc, stack_level, int_ack, exp);
        end
        exp_q.push_back(16'h0040);
        drive(0, 0, 0, 1, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || stack_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL tail_top: o_pc=%h lvl=%0d expected %h lvl 0", pc, stack_level, exp);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        drive(1, 0, 0, 0, 16'hFFFF, 16'h0);
        exp = exp_q.pop_front();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp) begin tests_failed++; $display("FAIL wrap: o_pc=%h expected %h", pc, exp); end
    endtask

    task automatic test_random_jumps();
        logic [15:0] model_pc, bus, exp;
        logic        do_jump;
        model_pc = pc;
        for (int i = 0; i < 40; i++) begin
            do_jump = ($urandom_range(0, 3) == 0);
            bus     = 16'($urandom_range(0, 16'hFFFF));
            aen     = 1'($urandom_range(0, 1));
            model_pc = do_jump ? bus : model_pc + 16'd1;
            exp_q.push_back(model_pc);
            drive(do_jump, 0, 0, 0, bus, 16'h0);
            exp = exp_q.pop_front();
            tests_run++;
            if (pc !== exp || address !== (aen ? exp : 16'h0000)) begin
                tests_failed++;
                $display("FAIL random_step: o_pc=%h o_address=%h aen=%b expected pc %h", pc, address, aen, exp);
            end
        end
        aen = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        drive(1, 1, 0, 0, 16'h0, 16'h3000);
        drive(1, 1, 1, 0, 16'h0, 16'h3100);
        #2;
        n_rst = 1'b0;
        set_en = 0; int_en = 0; lock = 0; ret = 0;
        #1;
        tests_run++;
        if (pc !== RESET_VEC || int_pending !== 1'b0 || stack_level !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h pend=%b lvl=%0d ovf=%b unf=%b expected 0000/0/0/0/0",
                     pc, int_pending, stack_level, ovf, unf);
        end
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.push_back(16'h0001);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        exp = exp_q.pop_front();
        tests_run++;
        if (pc !== exp || int_ack !== 1'b0 || stack_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL post_reset: o_pc=%h ack=%b lvl=%0d expected %h ack 0 lvl 0", pc, int_ack, stack_level, exp);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_interrupt();
        test_lock_irq();
        test_overflow();
        test_tail_chain();
        test_wrap();
        test_random_jumps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
